// File: rtl/debug_step_controller_if.sv
// Front-panel, CPU-gating and debugger-scan signals of the step controller.
// The slave modport is the controller; the master modport is the panel/CPU/debugger side.
interface debug_step_controller_if;
  logic        frame_done;
  logic        step;
  logic        run;
  logic        breakpoint_enable;
  logic [31:0] breakpoint_address;
  logic [31:0] cpu_if_pc;
  logic        cpu_clock_enable;
  logic [1:0]  state;
  logic [31:0] step_count;

  modport slave (
    input  frame_done, step, run, breakpoint_enable, breakpoint_address, cpu_if_pc,
    output cpu_clock_enable, state, step_count
  );

  modport master (
    output frame_done, step, run, breakpoint_enable, breakpoint_address, cpu_if_pc,
    input  cpu_clock_enable, state, step_count
  );
endinterface

// File: rtl/debug_step_controller.sv
// Gates the CPU clock enable so every CPU advance lands on a debugger frame boundary,
// giving pause, single-step, free run and a PC breakpoint.
module debug_step_controller #(
  parameter int RUN_FRAMES        = 1,
  parameter int FRAME_COUNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  debug_step_controller_if.slave dbg
);

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_STEP_WAIT = 2'd1,
    ST_RUNNING   = 2'd2,
    ST_BREAK     = 2'd3
  } state_t;

  localparam logic [FRAME_COUNT_WIDTH-1:0] LP_LAST_FRAME = FRAME_COUNT_WIDTH'(RUN_FRAMES - 1);

  state_t                       r_state;
  logic                         r_step_prev;
  logic                         r_cpu_ce;
  logic                         r_bp_suppress;
  logic [FRAME_COUNT_WIDTH-1:0] r_frame_cnt;
  logic [31:0]                  r_step_count;

  logic w_step_edge;
  logic w_frame;
  logic w_last_frame;
  logic w_bp_hit;

  assign w_step_edge  = dbg.step & ~r_step_prev;
  // A frame_done landing on a pulse cycle is dropped so the enable never stays high twice.
  assign w_frame      = dbg.frame_done & ~r_cpu_ce;
  assign w_last_frame = (r_frame_cnt == LP_LAST_FRAME);
  assign w_bp_hit     = dbg.breakpoint_enable & ~r_bp_suppress &
                        (dbg.cpu_if_pc == dbg.breakpoint_address);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_PAUSED;
      r_step_prev   <= 1'b0;
      r_cpu_ce      <= 1'b0;
      r_bp_suppress <= 1'b0;
      r_frame_cnt   <= '0;
      r_step_count  <= '0;
    end else begin
      r_step_prev <= dbg.step;
      r_cpu_ce    <= 1'b0;
      case (r_state)
        ST_PAUSED: begin
          if (dbg.run) begin
            r_state     <= ST_RUNNING;
            r_frame_cnt <= '0;
          end else if (w_step_edge) begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (w_frame) begin
            r_state       <= ST_PAUSED;
            r_cpu_ce      <= 1'b1;
            r_step_count  <= r_step_count + 32'd1;
            r_bp_suppress <= 1'b0;
          end
        end
        ST_RUNNING: begin
          if (!dbg.run) begin
            r_state <= ST_PAUSED;
          end else if (w_frame) begin
            if (!w_last_frame) begin
              r_frame_cnt <= r_frame_cnt + FRAME_COUNT_WIDTH'(1);
            end else if (w_bp_hit) begin
              r_state     <= ST_BREAK;
              r_frame_cnt <= '0;
            end else begin
              r_cpu_ce      <= 1'b1;
              r_step_count  <= r_step_count + 32'd1;
              r_frame_cnt   <= '0;
              r_bp_suppress <= 1'b0;
            end
          end
        end
        ST_BREAK: begin
          // Leaving BREAK masks the compare until the CPU has moved off the breaking PC.
          if (!dbg.run) begin
            r_bp_suppress <= 1'b1;
            r_state       <= w_step_edge ? ST_STEP_WAIT : ST_PAUSED;
          end
        end
        default: r_state <= ST_PAUSED;
      endcase
    end
  end

  assign dbg.cpu_clock_enable = r_cpu_ce;
  assign dbg.state            = r_state;
  assign dbg.step_count       = r_step_count;

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed bench for debug_step_controller with RUN_FRAMES=2 and a 2400-clock frame.
module tb_debug_step_controller;

  localparam int FP = 2400;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  int   bad;
  logic prev_ce;

  debug_step_controller_if dbg();

  debug_step_controller #(.RUN_FRAMES(2), .FRAME_COUNT_WIDTH(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .dbg   (dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One clock with frame_done = fd; tallies pulses, flags misplaced or back-to-back
  // pulses, and advances the modelled CPU PC by 4 on each pulse.
  task automatic cycle(input logic fd);
    dbg.frame_done = fd;
    tick();
    if (dbg.cpu_clock_enable === 1'b1) begin
      pulses++;
      if (!fd || prev_ce) bad++;
      dbg.cpu_if_pc = dbg.cpu_if_pc + 32'd4;
    end
    prev_ce = (dbg.cpu_clock_enable === 1'b1);
    dbg.frame_done = 1'b0;
  endtask

  task automatic frame;
    repeat (FP - 1) cycle(1'b0);
    cycle(1'b1);
  endtask

  task automatic do_reset;
    reset                  = 1'b1;
    dbg.frame_done         = 1'b0;
    dbg.step               = 1'b0;
    dbg.run                = 1'b0;
    dbg.breakpoint_enable  = 1'b0;
    dbg.breakpoint_address = 32'd0;
    dbg.cpu_if_pc          = 32'd0;
    repeat (2) tick();
    reset   = 1'b0;
    pulses  = 0;
    bad     = 0;
    prev_ce = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (dbg.state !== 2'd0 || dbg.cpu_clock_enable !== 1'b0 || dbg.step_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_values state=%0d ce=%0b cnt=%0d exp 0/0/0",
               dbg.state, dbg.cpu_clock_enable, dbg.step_count);
    end
    repeat (3) frame();
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL idle_pulses got=%0d exp=0", pulses);
    end
    checks++;
    if (dbg.state !== 2'd0 || dbg.step_count !== 32'd0) begin
      errors++; $display("FAIL idle_state state=%0d cnt=%0d exp 0/0", dbg.state, dbg.step_count);
    end
  endtask

  task automatic test_single_step;
    do_reset();
    repeat (100) cycle(1'b0);
    dbg.step = 1'b1;
    cycle(1'b0);
    checks++;
    if (dbg.state !== 2'd1) begin
      errors++; $display("FAIL step_wait_entry state=%0d exp=1", dbg.state);
    end
    repeat (FP - 102) cycle(1'b0);
    checks++;
    if (pulses !== 0 || dbg.state !== 2'd1) begin
      errors++; $display("FAIL step_early pulses=%0d state=%0d exp 0/1", pulses, dbg.state);
    end
    cycle(1'b1);
    checks++;
    if (dbg.cpu_clock_enable !== 1'b1 || dbg.state !== 2'd0 || dbg.step_count !== 32'd1) begin
      errors++;
      $display("FAIL step_grant ce=%0b state=%0d cnt=%0d exp 1/0/1",
               dbg.cpu_clock_enable, dbg.state, dbg.step_count);
    end
    cycle(1'b0);
    checks++;
    if (dbg.cpu_clock_enable !== 1'b0) begin
      errors++; $display("FAIL step_pulse_width ce=%0b exp=0", dbg.cpu_clock_enable);
    end
    dbg.step = 1'b0;
  endtask

  task automatic test_step_hold;
    do_reset();
    dbg.step = 1'b1;
    repeat (50) cycle(1'b0);
    dbg.step = 1'b0;
    repeat (5) cycle(1'b0);
    dbg.step = 1'b1;
    repeat (3) frame();
    checks++;
    if (pulses !== 1 || bad !== 0 || dbg.step_count !== 32'd1) begin
      errors++;
      $display("FAIL step_no_queue pulses=%0d bad=%0d cnt=%0d exp 1/0/1", pulses, bad, dbg.step_count);
    end
    checks++;
    if (dbg.state !== 2'd0) begin
      errors++; $display("FAIL step_hold_state state=%0d exp=0", dbg.state);
    end
    dbg.step = 1'b0;
  endtask

  task automatic test_run;
    do_reset();
    dbg.run = 1'b1;
    cycle(1'b0);
    checks++;
    if (dbg.state !== 2'd2) begin
      errors++; $display("FAIL run_entry state=%0d exp=2", dbg.state);
    end
    for (int k = 0; k < 6; k++) begin
      frame();
      checks++;
      if (dbg.cpu_clock_enable !== ((k % 2) == 1)) begin
        errors++; $display("FAIL run_frame%0d ce=%0b exp=%0b", k, dbg.cpu_clock_enable, (k % 2) == 1);
      end
    end
    checks++;
    if (pulses !== 3 || bad !== 0 || dbg.step_count !== 32'd3) begin
      errors++;
      $display("FAIL run_total pulses=%0d bad=%0d cnt=%0d exp 3/0/3", pulses, bad, dbg.step_count);
    end
    dbg.run = 1'b0;
    cycle(1'b1);
    checks++;
    if (dbg.state !== 2'd0 || dbg.cpu_clock_enable !== 1'b0) begin
      errors++;
      $display("FAIL run_stop state=%0d ce=%0b exp 0/0", dbg.state, dbg.cpu_clock_enable);
    end
  endtask

  task automatic test_breakpoint;
    do_reset();
    dbg.breakpoint_address = 32'h0000_000C;
    dbg.breakpoint_enable  = 1'b1;
    dbg.run                = 1'b1;
    repeat (8) frame();
    checks++;
    if (dbg.state !== 2'd3 || pulses !== 3 || dbg.cpu_if_pc !== 32'h0C) begin
      errors++;
      $display("FAIL bp_hit state=%0d pulses=%0d pc=%0h exp 3/3/c", dbg.state, pulses, dbg.cpu_if_pc);
    end
    frame();
    checks++;
    if (dbg.state !== 2'd3 || pulses !== 3) begin
      errors++; $display("FAIL bp_hold state=%0d pulses=%0d exp 3/3", dbg.state, pulses);
    end
    dbg.run = 1'b0;
    cycle(1'b0);
    checks++;
    if (dbg.state !== 2'd0) begin
      errors++; $display("FAIL bp_release state=%0d exp=0", dbg.state);
    end
    dbg.run = 1'b1;
    repeat (2) frame();
    checks++;
    if (pulses !== 4 || bad !== 0 || dbg.state !== 2'd2 || dbg.cpu_if_pc !== 32'h10 || dbg.step_count !== 32'd4) begin
      errors++;
      $display("FAIL bp_no_rebreak pulses=%0d bad=%0d state=%0d pc=%0h cnt=%0d exp 4/0/2/10/4",
               pulses, bad, dbg.state, dbg.cpu_if_pc, dbg.step_count);
    end
    dbg.run = 1'b0;
    cycle(1'b0);
  endtask

  task automatic test_reset_mid_pulse;
    do_reset();
    dbg.step = 1'b1;
    repeat (10) cycle(1'b0);
    dbg.step = 1'b0;
    cycle(1'b1);
    checks++;
    if (dbg.cpu_clock_enable !== 1'b1) begin
      errors++; $display("FAIL mid_pulse_grant ce=%0b exp=1", dbg.cpu_clock_enable);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dbg.cpu_clock_enable !== 1'b0 || dbg.state !== 2'd0 || dbg.step_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_pulse_reset ce=%0b state=%0d cnt=%0d exp 0/0/0",
               dbg.cpu_clock_enable, dbg.state, dbg.step_count);
    end
    reset   = 1'b0;
    pulses  = 0;
    prev_ce = 1'b0;
    frame();
    checks++;
    if (pulses !== 0 || dbg.state !== 2'd0) begin
      errors++; $display("FAIL mid_pulse_after pulses=%0d state=%0d exp 0/0", pulses, dbg.state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_step();
    test_step_hold();
    test_run();
    test_breakpoint();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_step_controller.md
Name: debug_step_controller

Overview:
- Sequences the pipelined CPU for the on-board terminal debugger by gating the CPU clock enable.
- Supports pause, single-step, free run and PC breakpoint.
- Every CPU advance is aligned to a terminal frame boundary, the cycle in which the debugger's terminal scan wraps. The 2400-cell debug screen therefore always shows one consistent pipeline snapshot.
- Sits between the front-panel inputs, the CPU's clock enable and the debugger's scan counter.

Parameters:
- RUN_FRAMES, 1, number of frame boundaries per CPU step while RUNNING (legal 1..255).
- FRAME_COUNT_WIDTH, 8, width of the internal frame counter.

Ports:
- clock  input  1  system clock, same domain as debugger and CPU.
- reset  input  1  synchronous, active-high reset.
- frame_done  input  1  one-cycle pulse when the debugger terminal address wraps from 2399 to 0.
- step  input  1  debounced step button level; rising edge is detected internally.
- run  input  1  run switch level.
- breakpoint_enable  input  1  arms the breakpoint compare.
- breakpoint_address  input  32  PC value to break on.
- cpu_if_pc  input  32  current fetch PC of the CPU.
- cpu_clock_enable  output  1  registered; high for exactly one clock per CPU step.
- state  output  2  0=PAUSED, 1=STEP_WAIT, 2=RUNNING, 3=BREAK.
- step_count  output  32  total enable pulses issued; wraps modulo 2^32.

Behaviour:
- All logic is synchronous to clock. Reset is synchronous and active-high and has priority over everything else.
- Reset values: state=PAUSED, cpu_clock_enable=0, step_count=0, frame counter=0, step edge register=0.
- step_edge = step & ~step_previous. step_previous is registered every clock, including while in reset (it takes 0).
- PAUSED:
  - run=1 -> RUNNING; frame counter cleared.
  - else step_edge -> STEP_WAIT.
  - run has priority over step_edge.
  - frame_done is ignored in PAUSED, including when it coincides with step_edge.
- STEP_WAIT:
  - On frame_done: cpu_clock_enable=1 on the next clock edge, state -> PAUSED.
  - Further step edges are ignored; there is no queueing.
  - Breakpoint is not checked here: a manual step always advances.
  - run is ignored until return to PAUSED.
- RUNNING:
  - run=0 -> PAUSED. No pulse that cycle, even if frame_done coincides.
  - On frame_done with frame counter == RUN_FRAMES-1:
    - if breakpoint_enable and cpu_if_pc == breakpoint_address: state -> BREAK, no pulse;
    - else cpu_clock_enable=1 on the next clock and the frame counter clears.
  - On frame_done otherwise: frame counter increments.
- BREAK:
  - Held while run=1.
  - run=0 -> PAUSED.
  - A step_edge while run=0 is handled as in PAUSED on the following cycle.
  - Re-entering RUNNING does not re-break at the same PC until at least one pulse has been issued. An internal flag suppresses the compare for the first pulse after leaving BREAK.
- Latency: cpu_clock_enable rises exactly one clock after the frame_done cycle that grants it.
  - Never high on two consecutive clocks.
  - Never high outside the cycle after frame_done.
- step_count increments in the same clock edge that sets cpu_clock_enable=1.
- Reset mid-pulse: cpu_clock_enable drops to 0 on the next clock; no further pulse.
- Breakpoint compare uses the cpu_if_pc present in the frame_done cycle. The PC is stable because the CPU is gated.

Test Plan:
- Reset, step low, 3 frame_done pulses every 2400 clocks -> state=0, cpu_clock_enable never 1, step_count=0.
- step rises at clock 100, frame_done at 2399 -> state=1 from 101; cpu_clock_enable=1 only at clock 2400; state=0; step_count=1.
- step held high across 3 frames, plus second edge while STEP_WAIT -> exactly 1 pulse.
- run=1 with RUN_FRAMES=2 over 6 frames -> 3 pulses, each one clock after every second frame_done; step_count=3.
- RUNNING, breakpoint_address=0x0000000C, breakpoint_enable=1, PC reaches 0x0C -> state=3, no pulse, PC holds.
  - Then run=0 -> state=0.
  - Then run=1 -> one pulse issued with no re-break at 0x0C.
- Reset asserted in the cycle after frame_done in STEP_WAIT -> cpu_clock_enable=0 next clock, state=0, step_count=0.
